// File: rtl/ram_geometry_pkg.sv
// rtl/ram_geometry_pkg.sv - RAM block geometry shared by ram_writer and ram_reader
package ram_geometry_pkg;

    localparam int unsigned CYCLES_PER_RAM_BLOCK = 64;
    localparam int unsigned RAM_DW               = 512;
    localparam int unsigned BURST_BYTES          = CYCLES_PER_RAM_BLOCK * RAM_DW / 8;

    // Byte address of a block for a given bus width; 64-bit, never wraps.
    function automatic logic [63:0] block_addr(input logic [31:0] idx, input int unsigned dw);
        return 64'(idx) * 64'(CYCLES_PER_RAM_BLOCK * dw / 8);
    endfunction

endpackage

// File: rtl/ram_writer_fifo.sv
// rtl/ram_writer_fifo.sv - first-word-fall-through block buffer for ram_writer
module ram_writer_fifo #(
    parameter int DW    = 512,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/ram_writer.sv
// rtl/ram_writer.sv - captures one AXI-Stream packet into RAM as exact-length AXI4 bursts
// Optional BRESP checking is enabled by defining RAM_WRITER_BRESP_CHECK_EN.
module ram_writer
    import ram_geometry_pkg::*;
#(
    parameter int          DW         = 512,
    parameter int          IW         = 5,
    parameter logic [31:0] MAX_BLOCKS = 32'd65536
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    output logic            idle,
    output logic [31:0]     full_blocks,
    output logic [7:0]      partial_block_cycles,
    output logic            overflow,
    output logic            bresp_err,
    input  logic [DW-1:0]   AXIS_IN_TDATA,
    input  logic            AXIS_IN_TVALID,
    input  logic            AXIS_IN_TLAST,
    output logic            AXIS_IN_TREADY,
    output logic [IW-1:0]   M_AXI_AWID,
    output logic [63:0]     M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [2:0]      M_AXI_AWPROT,
    output logic [3:0]      M_AXI_AWQOS,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [IW-1:0]   M_AXI_BID,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [IW-1:0]   M_AXI_ARID,
    output logic [63:0]     M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic            M_AXI_ARLOCK,
    output logic [3:0]      M_AXI_ARCACHE,
    output logic [2:0]      M_AXI_ARPROT,
    output logic [3:0]      M_AXI_ARQOS,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [IW-1:0]   M_AXI_RID,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP, S_DISCARD} state_t;

    localparam logic [7:0] CPB = 8'(CYCLES_PER_RAM_BLOCK);

    state_t      state_q, state_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [31:0] block_idx_q, block_idx_d, full_blocks_q, full_blocks_d;
    logic [7:0]  partial_q, partial_d, awlen_q, awlen_d;
    logic [63:0] awaddr_q, awaddr_d;
    logic        last_seen_q, last_seen_d, overflow_q, overflow_d, bresp_err_q, bresp_err_d;
    logic        tready_q, tready_d, awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d, wlast_q, wlast_d, bready_q, bready_d;
    logic        t_acc, fifo_push, fifo_pop, fifo_empty, fifo_full, bresp_bad;
    logic [DW-1:0] fifo_head;

`ifdef RAM_WRITER_BRESP_CHECK_EN
    assign bresp_bad = (M_AXI_BRESP != 2'b00);
`else
    assign bresp_bad = 1'b0;
`endif

    assign t_acc = AXIS_IN_TVALID && tready_q;

    ram_writer_fifo #(.DW(DW), .DEPTH(CYCLES_PER_RAM_BLOCK)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (AXIS_IN_TDATA),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        block_idx_d   = block_idx_q;
        full_blocks_d = full_blocks_q;
        partial_d     = partial_q;
        awlen_d       = awlen_q;
        awaddr_d      = awaddr_q;
        last_seen_d   = last_seen_q;
        overflow_d    = overflow_q;
        bresp_err_d   = bresp_err_q;
        tready_d      = tready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        wlast_d       = wlast_q;
        bready_d      = bready_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                full_blocks_d = '0;
                partial_d     = '0;
                overflow_d    = 1'b0;
                bresp_err_d   = 1'b0;
                block_idx_d   = '0;
                last_seen_d   = 1'b0;
                beat_cnt_d    = '0;
                tready_d      = 1'b1;
                state_d       = (MAX_BLOCKS == '0) ? S_DISCARD : S_FILL;
            end
            S_FILL: if (t_acc) begin
                fifo_push  = 1'b1;
                beat_cnt_d = beat_cnt_q + 8'd1;
                if (beat_cnt_d == CPB || AXIS_IN_TLAST) begin
                    last_seen_d = AXIS_IN_TLAST;
                    tready_d    = 1'b0;
                    awvalid_d   = 1'b1;
                    awaddr_d    = block_addr(block_idx_q, DW);
                    awlen_d     = beat_cnt_q;
                    state_d     = S_ADDR;
                end
            end
            S_ADDR: if (M_AXI_AWREADY) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b1;
                wlast_d   = (beat_cnt_q == 8'd1);
                wr_cnt_d  = '0;
                state_d   = S_DATA;
            end
            S_DATA: if (wvalid_q && M_AXI_WREADY) begin
                fifo_pop = 1'b1;
                if (wlast_q) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                    bready_d = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    wr_cnt_d = wr_cnt_q + 8'd1;
                    wlast_d  = (wr_cnt_q + 8'd2 == beat_cnt_q);
                end
            end
            S_RESP: if (M_AXI_BVALID) begin
                bready_d    = 1'b0;
                if (beat_cnt_q == CPB) full_blocks_d = full_blocks_q + 32'd1;
                else                   partial_d     = beat_cnt_q;
                if (bresp_bad) bresp_err_d = 1'b1;
                block_idx_d = block_idx_q + 32'd1;
                beat_cnt_d  = '0;
                // A packet that ends exactly on a block boundary never enters DISCARD.
                if (last_seen_q) begin
                    state_d = S_IDLE;
                end else begin
                    tready_d = 1'b1;
                    state_d  = (block_idx_d == MAX_BLOCKS) ? S_DISCARD : S_FILL;
                end
            end
            S_DISCARD: if (t_acc) begin
                overflow_d = 1'b1;
                if (AXIS_IN_TLAST) begin
                    tready_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            beat_cnt_q    <= '0;
            wr_cnt_q      <= '0;
            block_idx_q   <= '0;
            full_blocks_q <= '0;
            partial_q     <= '0;
            awlen_q       <= '0;
            awaddr_q      <= '0;
            last_seen_q   <= 1'b0;
            overflow_q    <= 1'b0;
            bresp_err_q   <= 1'b0;
            tready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wlast_q       <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            block_idx_q   <= block_idx_d;
            full_blocks_q <= full_blocks_d;
            partial_q     <= partial_d;
            awlen_q       <= awlen_d;
            awaddr_q      <= awaddr_d;
            last_seen_q   <= last_seen_d;
            overflow_q    <= overflow_d;
            bresp_err_q   <= bresp_err_d;
            tready_q      <= tready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            wlast_q       <= wlast_d;
            bready_q      <= bready_d;
        end
    end

    assign idle                 = (state_q == S_IDLE) && !start;
    assign full_blocks          = full_blocks_q;
    assign partial_block_cycles = partial_q;
    assign overflow             = overflow_q;
    assign bresp_err            = bresp_err_q;
    assign AXIS_IN_TREADY       = tready_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = fifo_head;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wlast_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARLEN   = '0;
    assign M_AXI_ARSIZE  = '0;
    assign M_AXI_ARBURST = '0;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{M_AXI_BID, M_AXI_BRESP, M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA,
                         M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, fifo_empty, fifo_full};

endmodule

// File: tb/tb_ram_writer.sv
// tb/tb_ram_writer.sv - directed self-checking bench for ram_writer (default and MAX_BLOCKS=2 instances)
module tb_ram_writer;
    import ram_geometry_pkg::*;

    localparam int DW = 512;
    localparam int IW = 5;
`ifdef RAM_WRITER_BRESP_CHECK_EN
    localparam logic EXP_BERR = 1'b1;
`else
    localparam logic EXP_BERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            resetn;
    logic            start [2] = '{1'b0, 1'b0};
    logic            idle [2];
    logic [31:0]     full_blocks [2];
    logic [7:0]      partial [2];
    logic            overflow [2], bresp_err [2];
    logic [DW-1:0]   tdata [2];
    logic            tvalid [2] = '{1'b0, 1'b0};
    logic            tlast [2] = '{1'b0, 1'b0};
    logic            tready [2];
    logic [IW-1:0]   awid [2], arid [2];
    logic [63:0]     awaddr [2], araddr [2];
    logic [7:0]      awlen [2], arlen [2];
    logic [2:0]      awsize [2], awprot [2], arsize [2], arprot [2];
    logic [1:0]      awburst [2], arburst [2];
    logic            awlock [2], arlock [2], awvalid [2], arvalid [2], rready [2];
    logic [3:0]      awcache [2], awqos [2], arcache [2], arqos [2];
    logic            awready [2] = '{1'b0, 1'b0};
    logic            wready [2] = '{1'b0, 1'b0};
    logic            bvalid [2] = '{1'b0, 1'b0};
    logic [1:0]      bresp [2] = '{2'd0, 2'd0};
    logic [DW-1:0]   wdata [2];
    logic [DW/8-1:0] wstrb [2];
    logic            wlast [2], wvalid [2], bready [2];

    ram_writer dut0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .idle(idle[0]),
        .full_blocks(full_blocks[0]), .partial_block_cycles(partial[0]),
        .overflow(overflow[0]), .bresp_err(bresp_err[0]),
        .AXIS_IN_TDATA(tdata[0]), .AXIS_IN_TVALID(tvalid[0]), .AXIS_IN_TLAST(tlast[0]), .AXIS_IN_TREADY(tready[0]),
        .M_AXI_AWID(awid[0]), .M_AXI_AWADDR(awaddr[0]), .M_AXI_AWLEN(awlen[0]), .M_AXI_AWSIZE(awsize[0]),
        .M_AXI_AWBURST(awburst[0]), .M_AXI_AWLOCK(awlock[0]), .M_AXI_AWCACHE(awcache[0]), .M_AXI_AWPROT(awprot[0]),
        .M_AXI_AWQOS(awqos[0]), .M_AXI_AWVALID(awvalid[0]), .M_AXI_AWREADY(awready[0]),
        .M_AXI_WDATA(wdata[0]), .M_AXI_WSTRB(wstrb[0]), .M_AXI_WLAST(wlast[0]), .M_AXI_WVALID(wvalid[0]),
        .M_AXI_WREADY(wready[0]), .M_AXI_BID('0), .M_AXI_BRESP(bresp[0]), .M_AXI_BVALID(bvalid[0]),
        .M_AXI_BREADY(bready[0]), .M_AXI_ARID(arid[0]), .M_AXI_ARADDR(araddr[0]), .M_AXI_ARLEN(arlen[0]),
        .M_AXI_ARSIZE(arsize[0]), .M_AXI_ARBURST(arburst[0]), .M_AXI_ARLOCK(arlock[0]), .M_AXI_ARCACHE(arcache[0]),
        .M_AXI_ARPROT(arprot[0]), .M_AXI_ARQOS(arqos[0]), .M_AXI_ARVALID(arvalid[0]), .M_AXI_ARREADY(1'b0),
        .M_AXI_RID('0), .M_AXI_RDATA('0), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b0), .M_AXI_RVALID(1'b0),
        .M_AXI_RREADY(rready[0])
    );

    ram_writer #(.MAX_BLOCKS(32'd2)) dut1 (
        .clk(clk), .resetn(resetn), .start(start[1]), .idle(idle[1]),
        .full_blocks(full_blocks[1]), .partial_block_cycles(partial[1]),
        .overflow(overflow[1]), .bresp_err(bresp_err[1]),
        .AXIS_IN_TDATA(tdata[1]), .AXIS_IN_TVALID(tvalid[1]), .AXIS_IN_TLAST(tlast[1]), .AXIS_IN_TREADY(tready[1]),
        .M_AXI_AWID(awid[1]), .M_AXI_AWADDR(awaddr[1]), .M_AXI_AWLEN(awlen[1]), .M_AXI_AWSIZE(awsize[1]),
        .M_AXI_AWBURST(awburst[1]), .M_AXI_AWLOCK(awlock[1]), .M_AXI_AWCACHE(awcache[1]), .M_AXI_AWPROT(awprot[1]),
        .M_AXI_AWQOS(awqos[1]), .M_AXI_AWVALID(awvalid[1]), .M_AXI_AWREADY(awready[1]),
        .M_AXI_WDATA(wdata[1]), .M_AXI_WSTRB(wstrb[1]), .M_AXI_WLAST(wlast[1]), .M_AXI_WVALID(wvalid[1]),
        .M_AXI_WREADY(wready[1]), .M_AXI_BID('0), .M_AXI_BRESP(bresp[1]), .M_AXI_BVALID(bvalid[1]),
        .M_AXI_BREADY(bready[1]), .M_AXI_ARID(arid[1]), .M_AXI_ARADDR(araddr[1]), .M_AXI_ARLEN(arlen[1]),
        .M_AXI_ARSIZE(arsize[1]), .M_AXI_ARBURST(arburst[1]), .M_AXI_ARLOCK(arlock[1]), .M_AXI_ARCACHE(arcache[1]),
        .M_AXI_ARPROT(arprot[1]), .M_AXI_ARQOS(arqos[1]), .M_AXI_ARVALID(arvalid[1]), .M_AXI_ARREADY(1'b0),
        .M_AXI_RID('0), .M_AXI_RDATA('0), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b0), .M_AXI_RVALID(1'b0),
        .M_AXI_RREADY(rready[1])
    );

    // Handshake monitor and RAM model (RAM contents kept for dut0 only).
    int            acc [2] = '{0, 0};
    int            aw_n [2] = '{0, 0};
    int            wb_n [2] = '{0, 0};
    int            w_cnt [2] = '{0, 0};
    int            pend_b [2] = '{0, 0};
    int            b_tot [2] = '{0, 0};
    int            wp [2] = '{0, 0};
    logic [63:0]   aw_addr_log [2][32];
    logic [7:0]    aw_len_log [2][32];
    int            wb_log [2][32];
    logic [DW-1:0] mem0 [512];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tvalid[i] && tready[i]) acc[i] <= acc[i] + 1;
            if (awvalid[i] && awready[i]) begin
                if (aw_n[i] < 32) begin
                    aw_addr_log[i][aw_n[i]] <= awaddr[i];
                    aw_len_log[i][aw_n[i]]  <= awlen[i];
                end
                aw_n[i] <= aw_n[i] + 1;
                wp[i]   <= int'(awaddr[i] >> 6);
            end
            if (wvalid[i] && wready[i]) begin
                if (i == 0 && wp[0] < 512) mem0[wp[0]] <= wdata[0];
                wp[i] <= wp[i] + 1;
                if (wlast[i]) begin
                    if (wb_n[i] < 32) wb_log[i][wb_n[i]] <= w_cnt[i] + 1;
                    wb_n[i]   <= wb_n[i] + 1;
                    w_cnt[i]  <= 0;
                    pend_b[i] <= pend_b[i] + 1;
                end else begin
                    w_cnt[i] <= w_cnt[i] + 1;
                end
            end
            if (bvalid[i] && bready[i]) begin
                pend_b[i] <= pend_b[i] - 1;
                b_tot[i]  <= b_tot[i] + 1;
            end
        end
    end

    bit stall [2];
    int berr_at [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            awready[i] = !stall[i] || ($urandom_range(0, 2) != 0);
            wready[i]  = !stall[i] || ($urandom_range(0, 2) != 0);
            if (pend_b[i] == 0)  bvalid[i] = 1'b0;
            else if (!bvalid[i]) bvalid[i] = !stall[i] || ($urandom_range(0, 2) == 0);
            bresp[i] = (b_tot[i] == berr_at[i]) ? 2'd2 : 2'd0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input logic [31:0] salt, input int k);
        logic [DW-1:0] w;
        for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = salt ^ 32'(k) ^ (32'(j) << 24);
        return w;
    endfunction

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic send_pkt(input int i, input int n, input logic [31:0] salt, input bit gaps);
        int base, k, prev_k, guard;
        base = acc[i];
        prev_k = -1;
        guard = 0;
        while ((acc[i] - base) < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            k = acc[i] - base;
            if (k >= n) begin
                tvalid[i] = 1'b0;
            end else if (!(tvalid[i] && k == prev_k)) begin
                if (!gaps || $urandom_range(0, 3) != 0) begin
                    tvalid[i] = 1'b1;
                    tdata[i]  = beat_word(salt, k);
                    tlast[i]  = (k == n - 1);
                end else begin
                    tvalid[i] = 1'b0;
                end
            end
            prev_k = k;
        end
        @(negedge clk);
        tvalid[i] = 1'b0;
        tlast[i]  = 1'b0;
        check("beats_accepted", 64'(acc[i] - base), 64'(n));
    endtask

    task automatic wait_idle(input int i);
        int g;
        g = 0;
        while (!idle[i] && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check("idle_reached", 64'(idle[i]), 64'd1);
    endtask

    task automatic check_mem(input int n, input logic [31:0] salt);
        int bad;
        bad = 0;
        for (int k = 0; k < n; k++) if (mem0[k] !== beat_word(salt, k)) bad++;
        check("ram_contents_bad_beats", 64'(bad), 64'd0);
    endtask

    int a0, w0;

    initial begin
        stall   = '{1'b0, 1'b0};
        berr_at = '{-1, -1};
        resetn  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awvalid", 64'(awvalid[0]), 64'd0);
        check("rst_wvalid", 64'(wvalid[0]), 64'd0);
        check("rst_wlast", 64'(wlast[0]), 64'd0);
        check("rst_bready", 64'(bready[0]), 64'd0);
        check("rst_tready", 64'(tready[0]), 64'd0);
        check("rst_full_blocks", 64'(full_blocks[0]), 64'd0);
        check("rst_partial", 64'(partial[0]), 64'd0);
        check("rst_overflow", 64'(overflow[0]), 64'd0);
        check("rst_bresp_err", 64'(bresp_err[0]), 64'd0);
        check("rst_idle", 64'(idle[0]), 64'd1);
        start[0] = 1'b1;
        #1;
        check("rst_idle_with_start", 64'(idle[0]), 64'd0);
        start[0] = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // 130 beats: two full bursts plus a 2-beat tail
        a0 = aw_n[0]; w0 = wb_n[0];
        pulse_start(0);
        send_pkt(0, 130, 32'h1000_0000, 1'b0);
        wait_idle(0);
        check("t130_bursts", 64'(aw_n[0] - a0), 64'd3);
        check("t130_addr0", aw_addr_log[0][a0], 64'd0);
        check("t130_addr1", aw_addr_log[0][a0+1], 64'd4096);
        check("t130_addr2", aw_addr_log[0][a0+2], 64'd8192);
        check("t130_len0", 64'(aw_len_log[0][a0]), 64'd63);
        check("t130_len1", 64'(aw_len_log[0][a0+1]), 64'd63);
        check("t130_len2", 64'(aw_len_log[0][a0+2]), 64'd1);
        check("t130_wbeats0", 64'(wb_log[0][w0]), 64'd64);
        check("t130_wbeats2", 64'(wb_log[0][w0+2]), 64'd2);
        check("t130_full", 64'(full_blocks[0]), 64'd2);
        check("t130_partial", 64'(partial[0]), 64'd2);
        check("t130_overflow", 64'(overflow[0]), 64'd0);
        check("awsize", 64'(awsize[0]), 64'd6);
        check("awburst", 64'(awburst[0]), 64'd1);
        check("wstrb_all_ones", 64'(&wstrb[0]), 64'd1);
        check("arvalid", 64'(arvalid[0]), 64'd0);
        check_mem(130, 32'h1000_0000);

        // exactly one block; a stray start while busy must be ignored
        a0 = aw_n[0]; w0 = wb_n[0];
        pulse_start(0);
        send_pkt(0, 64, 32'h2000_0000, 1'b0);
        pulse_start(0);
        wait_idle(0);
        check("t64_bursts", 64'(aw_n[0] - a0), 64'd1);
        check("t64_len", 64'(aw_len_log[0][a0]), 64'd63);
        check("t64_wbeats", 64'(wb_log[0][w0]), 64'd64);
        check("t64_full", 64'(full_blocks[0]), 64'd1);
        check("t64_partial", 64'(partial[0]), 64'd0);

        // single-beat packet
        a0 = aw_n[0]; w0 = wb_n[0];
        pulse_start(0);
        send_pkt(0, 1, 32'h3000_0000, 1'b0);
        wait_idle(0);
        check("t1_bursts", 64'(aw_n[0] - a0), 64'd1);
        check("t1_len", 64'(aw_len_log[0][a0]), 64'd0);
        check("t1_wbeats", 64'(wb_log[0][w0]), 64'd1);
        check("t1_full", 64'(full_blocks[0]), 64'd0);
        check("t1_partial", 64'(partial[0]), 64'd1);
        check_mem(1, 32'h3000_0000);

        // capacity of two blocks, 200-beat packet
        a0 = aw_n[1]; w0 = wb_n[1];
        pulse_start(1);
        send_pkt(1, 200, 32'h4000_0000, 1'b0);
        wait_idle(1);
        check("ovf_bursts", 64'(aw_n[1] - a0), 64'd2);
        check("ovf_addr1", aw_addr_log[1][a0+1], 64'd4096);
        check("ovf_len1", 64'(aw_len_log[1][a0+1]), 64'd63);
        check("ovf_wbeats1", 64'(wb_log[1][w0+1]), 64'd64);
        check("ovf_overflow", 64'(overflow[1]), 64'd1);
        check("ovf_full", 64'(full_blocks[1]), 64'd2);
        check("ovf_partial", 64'(partial[1]), 64'd0);

        // random stalls on every channel and TVALID gaps, 300 beats
        stall[0] = 1'b1;
        a0 = aw_n[0];
        pulse_start(0);
        send_pkt(0, 300, 32'h5000_0000, 1'b1);
        wait_idle(0);
        stall[0] = 1'b0;
        check("rnd_bursts", 64'(aw_n[0] - a0), 64'd5);
        check("rnd_len4", 64'(aw_len_log[0][a0+4]), 64'd43);
        check("rnd_full", 64'(full_blocks[0]), 64'd4);
        check("rnd_partial", 64'(partial[0]), 64'd44);
        check_mem(300, 32'h5000_0000);

        // error response on block 0, then a fresh start clears the flag
        berr_at[0] = b_tot[0];
        pulse_start(0);
        send_pkt(0, 70, 32'h6000_0000, 1'b0);
        wait_idle(0);
        berr_at[0] = -1;
        check("berr_flag", 64'(bresp_err[0]), 64'(EXP_BERR));
        check("berr_full", 64'(full_blocks[0]), 64'd1);
        check("berr_partial", 64'(partial[0]), 64'd6);
        pulse_start(0);
        send_pkt(0, 1, 32'h7000_0000, 1'b0);
        wait_idle(0);
        check("berr_cleared", 64'(bresp_err[0]), 64'd0);
        check("berr_next_partial", 64'(partial[0]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
